// File: rtl/mine_gen_pkg.sv
// Shared types and helpers for the mine index generator: FSM state encoding,
// the default LFSR seed, maximal-length tap masks and a ceil-log2 helper.
package mine_gen_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GEN  = 2'd1,
      OUT  = 2'd2,
      DONE = 2'd3
   } state_t;

   // Seed used at reset and whenever a zero seed is requested.
   localparam logic [15:0] SEED_DEFAULT = 16'h001F;

   // Feedback masks for a right-shifting Fibonacci LFSR that inserts at the MSB.
   // Bit i of the mask is the coefficient of x^i of a primitive polynomial of
   // degree width (the x^width term is implicit), so bit 0 is always set.
   function automatic logic [15:0] taps(input int width);
      case (width)
         4:       taps = 16'h0009; // x^4+x^3+1
         5:       taps = 16'h0009; // x^5+x^3+1
         6:       taps = 16'h0021; // x^6+x^5+1
         7:       taps = 16'h0041; // x^7+x^6+1
         8:       taps = 16'h0071; // x^8+x^6+x^5+x^4+1
         9:       taps = 16'h0021; // x^9+x^5+1
         10:      taps = 16'h0081; // x^10+x^7+1
         11:      taps = 16'h0201; // x^11+x^9+1
         12:      taps = 16'h0053; // x^12+x^6+x^4+x+1
         13:      taps = 16'h001B; // x^13+x^4+x^3+x+1
         14:      taps = 16'h002B; // x^14+x^5+x^3+x+1
         15:      taps = 16'h4001; // x^15+x^14+1
         16:      taps = 16'hA011; // x^16+x^15+x^13+x^4+1
         default: taps = 16'h0071;
      endcase
   endfunction

   // Smallest r with 2**r >= value (at least 1 so counters are never zero width).
   function automatic int clog2(input int value);
      int r;
      r = 1;
      for (int i = 1; i < 31; i++) begin
         if ((1 << r) < value) r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/mine_index_gen_lfsr_fib.sv
// Fibonacci LFSR: feedback is the XOR of the tapped bits, shifted in at the
// MSB. A load of zero substitutes the default seed so the register can never
// lock up in the all-zero state.
module lfsr_fib
   import mine_gen_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             step,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] q
);

   localparam logic [WIDTH-1:0] MASK = WIDTH'(taps(WIDTH));
   localparam logic [WIDTH-1:0] SEED = WIDTH'(SEED_DEFAULT);

   logic [WIDTH-1:0] q_q, q_d;
   logic             fb;

   // Next value: load wins over step; otherwise hold.
   always_comb begin
      fb  = ^(q_q & MASK);
      q_d = q_q;
      if (load) begin
         q_d = (load_val == '0) ? SEED : load_val;
      end else if (step) begin
         q_d = {fb, q_q[WIDTH-1:1]};
      end
   end

   // State register with synchronous active-low reset to the default seed.
   always_ff @(posedge clock) begin
      if (!reset) q_q <= SEED;
      else        q_q <= q_d;
   end

   assign q = q_q;

endmodule

// File: rtl/mine_index_gen.sv
// Mine placement generator: an LFSR proposes cell indices, out-of-range and
// already-placed candidates are rejected, and MINES unique indices are handed
// off over a valid/ready port while being accumulated in a CELLS-bit map.
// Optional build macro: MINE_GEN_SAFE_CELL_EN adds safe_idx, a cell that is
// never chosen (sampled on start).
module mine_index_gen
   import mine_gen_pkg::*;
#(
   parameter int LFSR_W = 8,
   parameter int CELLS  = 81,
   parameter int MINES  = 10,
   parameter int IDX_W  = 7
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              seed_load,
   input  logic [LFSR_W-1:0] seed,
`ifdef MINE_GEN_SAFE_CELL_EN
   input  logic [IDX_W-1:0]  safe_idx,
`endif
   output logic [IDX_W-1:0]  idx,
   output logic              idx_valid,
   input  logic              idx_ready,
   output logic [CELLS-1:0]  mine_map,
   output logic              busy,
   output logic              done
);

   localparam int MAP_W = 1 << IDX_W;
   localparam int RW    = clog2(MINES + 1);
   localparam logic [IDX_W:0]  CELLS_LIM = (IDX_W + 1)'(CELLS);
   localparam logic [RW-1:0]   MINES_R   = RW'(MINES);
   localparam logic [RW-1:0]   ONE_R     = RW'(1);

   state_t            state_q, state_d;
   logic [LFSR_W-1:0] lfsr_q;
   logic [IDX_W-1:0]  cand;
   logic [MAP_W-1:0]  map_ext;
   logic              idle_like, start_go, cand_ok, handshake;
   logic              lfsr_step, lfsr_load;

   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              valid_q, valid_d;
   logic [CELLS-1:0]  mine_map_q, mine_map_d;
   logic [RW-1:0]     remaining_q, remaining_d;
   logic              done_q, done_d;
`ifdef MINE_GEN_SAFE_CELL_EN
   logic [IDX_W-1:0]  safe_q, safe_d;
`endif

   // The LFSR runs freely except while an index waits in OUT.
   assign idle_like = (state_q == IDLE) || (state_q == DONE);
   assign lfsr_step = (state_q != OUT);
   assign lfsr_load = idle_like && seed_load;

   lfsr_fib #(.WIDTH(LFSR_W)) u_lfsr (
      .clock    (clock),
      .reset    (reset),
      .step     (lfsr_step),
      .load     (lfsr_load),
      .load_val (seed),
      .q        (lfsr_q)
   );

   // Candidate is the low IDX_W bits; the map is zero-padded to the full index
   // range so out-of-range candidates can be looked up safely.
   assign cand    = IDX_W'(lfsr_q);
   assign map_ext = MAP_W'(mine_map_q);

   // Candidate acceptance and handshake qualifiers.
   always_comb begin
      cand_ok = ({1'b0, cand} < CELLS_LIM) && !map_ext[cand];
`ifdef MINE_GEN_SAFE_CELL_EN
      if (cand == safe_q) cand_ok = 1'b0;
`endif
      start_go  = idle_like && start && !seed_load;
      handshake = (state_q == OUT) && valid_q && idx_ready;
   end

   // FSM state register.
   always_ff @(posedge clock) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // FSM next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, DONE: if (start_go) state_d = GEN;
         GEN:        if (cand_ok)  state_d = OUT;
         OUT: begin
            if (handshake) state_d = (remaining_q == ONE_R) ? DONE : GEN;
         end
         default:    state_d = IDLE;
      endcase
   end

   // FSM outputs.
   always_comb begin
      busy = (state_q == GEN) || (state_q == OUT);
   end

   // Datapath next-state: run setup, index capture and handshake bookkeeping.
   always_comb begin
      idx_d       = idx_q;
      valid_d     = valid_q;
      mine_map_d  = mine_map_q;
      remaining_d = remaining_q;
      done_d      = done_q;
`ifdef MINE_GEN_SAFE_CELL_EN
      safe_d      = safe_q;
`endif
      if (start_go) begin
         mine_map_d  = '0;
         remaining_d = MINES_R;
         done_d      = 1'b0;
`ifdef MINE_GEN_SAFE_CELL_EN
         safe_d      = safe_idx;
`endif
      end
      if ((state_q == GEN) && cand_ok) begin
         idx_d      = cand;
         valid_d    = 1'b1;
         mine_map_d = mine_map_q | (CELLS'(1) << cand);
      end
      if (handshake) begin
         valid_d     = 1'b0;
         remaining_d = remaining_q - ONE_R;
         if (remaining_q == ONE_R) done_d = 1'b1;
      end
   end

   // Datapath registers; reset also aborts any run in progress.
   always_ff @(posedge clock) begin
      if (!reset) begin
         idx_q       <= '0;
         valid_q     <= 1'b0;
         mine_map_q  <= '0;
         remaining_q <= '0;
         done_q      <= 1'b0;
`ifdef MINE_GEN_SAFE_CELL_EN
         safe_q      <= '0;
`endif
      end else begin
         idx_q       <= idx_d;
         valid_q     <= valid_d;
         mine_map_q  <= mine_map_d;
         remaining_q <= remaining_d;
         done_q      <= done_d;
`ifdef MINE_GEN_SAFE_CELL_EN
         safe_q      <= safe_d;
`endif
      end
   end

   assign idx       = idx_q;
   assign idx_valid = valid_q;
   assign mine_map  = mine_map_q;
   assign done      = done_q;

endmodule

// File: tb/tb_mine_index_gen.sv
// Directed bench for mine_index_gen: LFSR sequence table, nominal run,
// backpressure, restart, abort by reset, full board and (with
// MINE_GEN_SAFE_CELL_EN) the safe cell.
module tb_mine_index_gen;
   import mine_gen_pkg::*;

`ifdef MINE_GEN_SAFE_CELL_EN
   localparam int          FB_MINES = 15;
   localparam logic [15:0] FB_EXP   = 16'hFFFE;
`else
   localparam int          FB_MINES = 16;
   localparam logic [15:0] FB_EXP   = 16'hFFFF;
`endif

   logic        clock = 1'b0;
   logic        reset;
   logic        start, seed_load, idx_ready;
   logic [7:0]  seed;
   logic [6:0]  idx;
   logic        idx_valid, busy, done;
   logic [80:0] mine_map;

   logic        fb_start, fb_seed_load, fb_ready;
   logic [7:0]  fb_seed;
   logic [3:0]  fb_idx;
   logic        fb_valid, fb_busy, fb_done;
   logic [15:0] fb_map;
`ifdef MINE_GEN_SAFE_CELL_EN
   logic [6:0]  safe_idx;
   logic [3:0]  fb_safe;
`endif

   always #5 clock = ~clock;

   mine_index_gen dut (
      .clock(clock), .reset(reset), .start(start), .seed_load(seed_load),
      .seed(seed),
`ifdef MINE_GEN_SAFE_CELL_EN
      .safe_idx(safe_idx),
`endif
      .idx(idx), .idx_valid(idx_valid), .idx_ready(idx_ready),
      .mine_map(mine_map), .busy(busy), .done(done)
   );

   mine_index_gen #(.LFSR_W(8), .CELLS(16), .MINES(FB_MINES), .IDX_W(4)) dut_fb (
      .clock(clock), .reset(reset), .start(fb_start), .seed_load(fb_seed_load),
      .seed(fb_seed),
`ifdef MINE_GEN_SAFE_CELL_EN
      .safe_idx(fb_safe),
`endif
      .idx(fb_idx), .idx_valid(fb_valid), .idx_ready(fb_ready),
      .mine_map(fb_map), .busy(fb_busy), .done(fb_done)
   );

   int errors = 0;
   int checks = 0;
   int hs_cnt;
   logic [6:0] hs_idx [16];
   logic timed_out;

   typedef struct {
      logic       sl;
      logic [7:0] sd;
      logic [7:0] exp_lfsr;
      logic       exp_busy;
   } vec_t;
   vec_t vecs [8];

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic seed_and_start(input logic [7:0] sd);
      seed_load = 1'b1; seed = sd;
      tick();
      seed_load = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Records each index whose handshake occurs at the next edge.
   task automatic collect(input int max_hs, input int budget);
      hs_cnt = 0; timed_out = 1'b1;
      for (int c = 0; c < budget; c++) begin
         if (done || hs_cnt == max_hs) begin
            timed_out = 1'b0;
            break;
         end
         if (idx_valid && idx_ready) begin
            if (hs_cnt < 16) hs_idx[hs_cnt] = idx;
            hs_cnt++;
         end
         tick();
      end
   endtask

   initial begin
      logic [127:0] seen;
      logic [80:0]  emap;
      logic [6:0]   exp_first [6];
      logic [6:0]   s_idx;
      logic [80:0]  s_map;
      logic [7:0]   s_lfsr;
      int dups, fb_hs;

      vecs[0] = '{1'b1, 8'h1F, 8'h1F, 1'b0};
      vecs[1] = '{1'b0, 8'h00, 8'h0F, 1'b0};
      vecs[2] = '{1'b0, 8'h00, 8'h87, 1'b0};
      vecs[3] = '{1'b0, 8'h00, 8'hC3, 1'b0};
      vecs[4] = '{1'b1, 8'h00, 8'h1F, 1'b0};
      vecs[5] = '{1'b0, 8'h00, 8'h0F, 1'b0};
      vecs[6] = '{1'b1, 8'hA5, 8'hA5, 1'b0};
      vecs[7] = '{1'b0, 8'h00, 8'h52, 1'b0};
      exp_first[0] = 7'd15; exp_first[1] = 7'd7;  exp_first[2] = 7'd67;
      exp_first[3] = 7'd48; exp_first[4] = 7'd44; exp_first[5] = 7'd22;

      reset = 1'b0; start = 1'b0; seed_load = 1'b0; seed = 8'h00; idx_ready = 1'b1;
      fb_start = 1'b0; fb_seed_load = 1'b0; fb_seed = 8'h00; fb_ready = 1'b1;
`ifdef MINE_GEN_SAFE_CELL_EN
      safe_idx = 7'd40; fb_safe = 4'd0;
`endif

      // Reset state
      repeat (3) tick();
      check("rst_valid", idx_valid, 0);
      check("rst_done", done, 0);
      check("rst_busy", busy, 0);
      check("rst_map", mine_map, 0);
      check("rst_lfsr", dut.lfsr_q, 8'h1F);
      reset = 1'b1;

      // LFSR sequence and seed loading (including zero seed)
      for (int i = 0; i < 8; i++) begin
         seed_load = vecs[i].sl; seed = vecs[i].sd;
         tick();
         check($sformatf("lfsr_vec%0d", i), dut.lfsr_q, vecs[i].exp_lfsr);
         check($sformatf("busy_vec%0d", i), busy, vecs[i].exp_busy);
      end
      seed_load = 1'b0;

      // Nominal run from seed 1F
      seed_and_start(8'h1F);
      check("nom_busy_start", busy, 1);
      check("nom_valid_start", idx_valid, 0);
      check("nom_remaining", dut.remaining_q, 10);
      tick();
      check("nom_first_valid", idx_valid, 1);
      collect(16, 2000);
      check("nom_timeout", timed_out, 0);
      check("nom_handshakes", hs_cnt, 10);
      seen = '0; emap = '0; dups = 0;
      for (int k = 0; k < 10 && k < hs_cnt; k++) begin
         check($sformatf("nom_range%0d", k), (hs_idx[k] < 7'd81), 1);
         if (seen[hs_idx[k]]) dups++;
         seen[hs_idx[k]] = 1'b1;
         emap[hs_idx[k]] = 1'b1;
         if (k < 6) check($sformatf("nom_idx%0d", k), hs_idx[k], exp_first[k]);
      end
      check("nom_distinct", dups, 0);
      check("nom_popcount", $countones(mine_map), 10);
      check("nom_map", mine_map, emap);
      check("nom_done", done, 1);
      check("nom_busy_end", busy, 0);

      // Backpressure, also restarting from DONE
      idx_ready = 1'b0;
      seed_and_start(8'h1F);
      check("bp_done_cleared", done, 0);
      check("bp_map_cleared", mine_map, 0);
      timed_out = 1'b1;
      for (int c = 0; c < 50; c++) begin
         if (idx_valid) begin timed_out = 1'b0; break; end
         tick();
      end
      check("bp_wait", timed_out, 0);
      check("bp_idx", idx, 15);
      s_idx = idx; s_map = mine_map; s_lfsr = dut.lfsr_q;
      for (int c = 0; c < 5; c++) begin
         tick();
         check($sformatf("bp_hold_idx%0d", c), idx, s_idx);
         check($sformatf("bp_hold_map%0d", c), mine_map, s_map);
         check($sformatf("bp_hold_lfsr%0d", c), dut.lfsr_q, s_lfsr);
         check($sformatf("bp_hold_valid%0d", c), idx_valid, 1);
      end
      check("bp_rem_before", dut.remaining_q, 10);
      idx_ready = 1'b1;
      tick();
      idx_ready = 1'b0;
      check("bp_valid_drop", idx_valid, 0);
      check("bp_rem_after", dut.remaining_q, 9);
      repeat (3) tick();
      check("bp_rem_once", dut.remaining_q, 9);
      idx_ready = 1'b1;
      collect(16, 2000);
      check("bp_timeout", timed_out, 0);
      check("bp_rest_hs", hs_cnt, 9);
      check("bp_done", done, 1);

      // Abort by reset after four handshakes
      seed_and_start(8'h3C);
      collect(4, 2000);
      check("abort_timeout", timed_out, 0);
      reset = 1'b0;
      tick();
      check("abort_map", mine_map, 0);
      check("abort_state", dut.state_q, IDLE);
      check("abort_busy", busy, 0);
      check("abort_valid", idx_valid, 0);
      check("abort_lfsr", dut.lfsr_q, 8'h1F);
      reset = 1'b1;

      // Full board; start while busy must be ignored
      fb_start = 1'b1;
      tick();
      fb_start = 1'b0;
      fb_hs = 0;
      for (int c = 0; c < 2000; c++) begin
         if (fb_hs == 8) break;
         if (fb_valid && fb_ready) fb_hs++;
         tick();
      end
      check("fb_mid_hs", fb_hs, 8);
      fb_start = 1'b1;
      tick();
      fb_start = 1'b0;
      check("fb_start_ignored", ($countones(fb_map) >= 8), 1);
      check("fb_busy_mid", fb_busy, 1);
      timed_out = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         if (fb_done) begin timed_out = 1'b0; break; end
         tick();
      end
      check("fb_timeout", timed_out, 0);
      check("fb_map", fb_map, FB_EXP);
      check("fb_done", fb_done, 1);
      check("fb_busy_end", fb_busy, 0);

`ifdef MINE_GEN_SAFE_CELL_EN
      // Safe cell never emitted across many seeds
      begin
         int hits, touts, short_runs;
         hits = 0; touts = 0; short_runs = 0;
         for (int r = 0; r < 50; r++) begin
            seed_and_start(8'(r * 5 + 3));
            collect(16, 3000);
            if (timed_out) touts++;
            if (hs_cnt != 10) short_runs++;
            for (int k = 0; k < 10 && k < hs_cnt; k++)
               if (hs_idx[k] == 7'd40) hits++;
            if (mine_map[40]) hits++;
         end
         check("safe_timeouts", touts, 0);
         check("safe_counts", short_runs, 0);
         check("safe_hits", hits, 0);
      end
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
